rom_image_loader: RTL
=====================

Name: rom_image_loader

Overview:
- Fills a 2**ADDR_W x 8 ROM-style memory (the 16K x 8 23128 image by default) from a byte stream at power-up, before the 6502 is released.
- Writer-side counterpart to the registered-read ROM: it writes every byte, then optionally reads the whole image back through the ROM's 1-cycle-latency, chip-select/output-enable read port and checks an 8-bit checksum.
- Sits between the host/boot byte source and the ROM storage; `done` gates CPU reset release.

Parameters:
ADDR_W, 14, memory address width; the image length is 2**ADDR_W bytes
DATA_W, 8, data width; all arithmetic uses this width

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a load when in IDLE or DONE
s_data  input  DATA_W  stream byte
s_valid  input  1  stream byte valid
s_ready  output  1  loader accepts byte this cycle
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  write data
mem_we  output  1  write strobe, one cycle per byte
mem_cs_b  output  1  active-low chip select for readback
mem_oe_b  output  1  active-low output enable for readback
mem_rdata  input  DATA_W  read data, valid 1 cycle after address is presented with cs_b=oe_b=0
busy  output  1  high in any state other than IDLE/DONE
done  output  1  high in DONE
error  output  1  checksum mismatch, valid when done=1
checksum  output  DATA_W  running sum of bytes written, mod 2**DATA_W

Behaviour:
- Reset, whatever the current state: state=IDLE. All of the following are 0: s_ready, mem_we, busy, done, error, checksum, mem_addr, mem_wdata. mem_cs_b=1 and mem_oe_b=1. Reset mid-load abandons the load; memory contents are left undefined.
- States: IDLE, LOAD, VERIFY, DRAIN, CHECK, DONE.
- IDLE/DONE + start=1:
  - go to LOAD next cycle;
  - clear the address counter, checksum, error and done.
  - In DONE, done stays high until start is seen.
- LOAD:
  - s_ready=1 (combinational from state).
  - Handshake when s_valid&&s_ready. The next cycle then has mem_we=1, mem_addr=counter, mem_wdata=byte, and checksum+=byte (wrap mod 256).
  - The counter increments per accepted byte.
  - s_valid low inserts bubbles; mem_we=0 in those cycles.
  - After byte 2**ADDR_W-1 is accepted, s_ready drops the next cycle and no further bytes are accepted. The counter wraps to 0.
  - Then go to VERIFY (macro defined) or DONE (macro undefined).
  - start during LOAD/VERIFY/DRAIN/CHECK is ignored.
- VERIFY:
  - mem_cs_b=0, mem_oe_b=0, mem_we=0.
  - mem_addr steps 0..2**ADDR_W-1, one per cycle, with no stalls.
  - mem_rdata is accumulated into a separate read sum one cycle after its address is issued (delayed valid flag).
  - After the last address is issued, go to DRAIN.
- DRAIN:
  - One cycle; cs_b/oe_b stay 0.
  - The final returned byte is accumulated.
  - Go to CHECK.
- CHECK:
  - One cycle; cs_b/oe_b=1.
  - error <= (readsum != checksum).
  - Go to DONE.
- DONE: done=1, busy=0. error and checksum hold.
- Timing:
  - Load latency is N accepted bytes + 1 cycle.
  - Verify latency is N + 2 cycles after LOAD exits.
- mem_cs_b/mem_oe_b are 1 in every state except VERIFY/DRAIN. mem_we is never asserted while cs_b=0.

Optional Feature:
- Macro: ROM_LOADER_VERIFY_EN.
- Defined: VERIFY/DRAIN/CHECK are present as described above, and error reflects the readback comparison.
- Undefined: LOAD goes directly to DONE. error is tied 0, mem_cs_b/mem_oe_b are tied 1, and mem_rdata is unused.

Test Plan:
- ADDR_W=4, reset, start, stream bytes 0x00..0x0F back-to-back -> 16 writes at addr 0..15 with matching data; checksum=0x78; done=1, error=0.
- ADDR_W=4, stream 16 bytes of 0xFF with s_valid low every other cycle -> no write in bubble cycles; checksum=0xF0 (wrap); done=1.
- ADDR_W=4, VERIFY_EN, memory model corrupts addr 7 on readback (value XOR 0x01) -> error=1 after CHECK; checksum is unchanged.
- Assert rst after 5 bytes are accepted -> next cycle state IDLE; all outputs at reset values. Then start + 16 bytes -> normal completion.
- Pulse start during LOAD, and offer extra s_valid bytes after the 16th -> start ignored; s_ready=0, no 17th write; checksum excludes extras.
- Without VERIFY_EN -> done asserts 1 cycle after the 16th write; mem_cs_b/mem_oe_b stay 1 throughout.

Source files
------------

// File: rtl/rom_image_loader.sv
// Boot-time ROM image loader: streams 2**ADDR_W bytes into ROM storage, keeps an 8-bit checksum, and holds `done` low until the image is in place.
// Define ROM_LOADER_VERIFY_EN to add the readback pass (VERIFY/DRAIN/CHECK) that compares a read sum with the write checksum.
module rom_image_loader #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_cs_b,
  output logic              mem_oe_b,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  // Modular byte sum shared by the write checksum and the readback sum.
  function automatic logic [DATA_W-1:0] sum_add(input logic [DATA_W-1:0] acc,
                                                input logic [DATA_W-1:0] val);
    sum_add = acc + val;
  endfunction

  state_t              state_r, state_n;
  logic [ADDR_W-1:0]   addr_r, addr_n;
  logic                full_r, full_n;
  logic                mem_we_r, mem_we_n;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_n;
  logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_n;
  logic [DATA_W-1:0]   checksum_r, checksum_n;
  logic                s_ready_r, s_ready_n;
  logic                busy_r, busy_n;
  logic                done_r, done_n;
  logic                accept_s;

`ifdef ROM_LOADER_VERIFY_EN
  logic                error_r, error_n;
  logic                cs_b_r, cs_b_n;
  logic                rd_pend_r, rd_pend_n;
  logic [DATA_W-1:0]   readsum_r, readsum_n;
`else
  logic                unused_rdata_s;
  assign unused_rdata_s = ^mem_rdata;
`endif

  assign accept_s = s_valid && s_ready_r;

  // Next-state and next-output computation for the loader sequence.
  always_comb begin
    state_n     = state_r;
    addr_n      = addr_r;
    full_n      = full_r;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr_r;
    mem_wdata_n = mem_wdata_r;
    checksum_n  = checksum_r;
`ifdef ROM_LOADER_VERIFY_EN
    error_n     = error_r;
    rd_pend_n   = 1'b0;
    readsum_n   = readsum_r;
`endif
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n    = ST_LOAD;
          addr_n     = ADDR_ZERO;
          full_n     = 1'b0;
          checksum_n = DATA_ZERO;
`ifdef ROM_LOADER_VERIFY_EN
          error_n    = 1'b0;
          readsum_n  = DATA_ZERO;
`endif
        end else begin
          state_n = state_r;
        end
      end
      ST_LOAD: begin
        // full_r marks the cycle that carries the final write; s_ready is already low.
        if (full_r) begin
          full_n     = 1'b0;
          mem_addr_n = ADDR_ZERO;
`ifdef ROM_LOADER_VERIFY_EN
          state_n    = ST_VERIFY;
`else
          state_n    = ST_DONE;
`endif
        end else if (accept_s) begin
          mem_we_n    = 1'b1;
          mem_addr_n  = addr_r;
          mem_wdata_n = s_data;
          checksum_n  = sum_add(checksum_r, s_data);
          addr_n      = addr_r + ADDR_W'(1);
          if (addr_r == ADDR_LAST) begin
            full_n = 1'b1;
          end else begin
            full_n = 1'b0;
          end
        end else begin
          mem_we_n = 1'b0;
        end
      end
`ifdef ROM_LOADER_VERIFY_EN
      ST_VERIFY: begin
        mem_addr_n = mem_addr_r + ADDR_W'(1);
        rd_pend_n  = 1'b1;
        // The first VERIFY cycle has no returned byte yet.
        if (rd_pend_r) begin
          readsum_n = sum_add(readsum_r, mem_rdata);
        end else begin
          readsum_n = readsum_r;
        end
        if (mem_addr_r == ADDR_LAST) begin
          state_n = ST_DRAIN;
        end else begin
          state_n = ST_VERIFY;
        end
      end
      ST_DRAIN: begin
        readsum_n = sum_add(readsum_r, mem_rdata);
        state_n   = ST_CHECK;
      end
      ST_CHECK: begin
        error_n = (readsum_r != checksum_r);
        state_n = ST_DONE;
      end
`endif
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    s_ready_n = (state_n == ST_LOAD) && !full_n;
    busy_n    = (state_n != ST_IDLE) && (state_n != ST_DONE);
    done_n    = (state_n == ST_DONE);
`ifdef ROM_LOADER_VERIFY_EN
    cs_b_n    = !((state_n == ST_VERIFY) || (state_n == ST_DRAIN));
`endif
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      addr_r      <= ADDR_ZERO;
      full_r      <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= ADDR_ZERO;
      mem_wdata_r <= DATA_ZERO;
      checksum_r  <= DATA_ZERO;
      s_ready_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef ROM_LOADER_VERIFY_EN
      error_r     <= 1'b0;
      cs_b_r      <= 1'b1;
      rd_pend_r   <= 1'b0;
      readsum_r   <= DATA_ZERO;
`endif
    end else begin
      state_r     <= state_n;
      addr_r      <= addr_n;
      full_r      <= full_n;
      mem_we_r    <= mem_we_n;
      mem_addr_r  <= mem_addr_n;
      mem_wdata_r <= mem_wdata_n;
      checksum_r  <= checksum_n;
      s_ready_r   <= s_ready_n;
      busy_r      <= busy_n;
      done_r      <= done_n;
`ifdef ROM_LOADER_VERIFY_EN
      error_r     <= error_n;
      cs_b_r      <= cs_b_n;
      rd_pend_r   <= rd_pend_n;
      readsum_r   <= readsum_n;
`endif
    end
  end

  assign s_ready   = s_ready_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_we    = mem_we_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign checksum  = checksum_r;
`ifdef ROM_LOADER_VERIFY_EN
  assign error     = error_r;
  assign mem_cs_b  = cs_b_r;
  assign mem_oe_b  = cs_b_r;
`else
  assign error     = 1'b0;
  assign mem_cs_b  = 1'b1;
  assign mem_oe_b  = 1'b1;
`endif

endmodule
